// File: rtl/assoc_fill_controller.sv
// ---------------------------------------------------------------------------
// assoc_fill_controller
//
// Miss-handling front end for the fully associative data bank of mips_core.
// A single-word read request is probed against the bank; hits are returned
// straight from the bank's registered read data, misses are fetched from the
// next memory level, written into the bank for exactly one cycle, and then
// returned. Only one request is in flight at a time.
//
// Structure: a three-process FSM (state register, next-state/datapath logic,
// output decode). The handshake and bank-write outputs are registered from
// the next-state decode, so they change on the same edge that enters the
// owning state. req_ready and bank_raddr stay combinational because the bank
// must see the request address in the same cycle it is accepted.
// ---------------------------------------------------------------------------
module assoc_fill_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_hit,

    output logic [ADDR_WIDTH-1:0] bank_raddr,
    input  logic [DATA_WIDTH-1:0] bank_rdata,
    input  logic                  bank_hit,
    output logic                  bank_we,
    output logic [ADDR_WIDTH-1:0] bank_waddr,
    output logic [DATA_WIDTH-1:0] bank_wdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,

    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PROBE    = 3'd1,
        ST_MEM_REQ  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_FILL     = 3'd4,
        ST_RESP     = 3'd5
    } state_t;

    // Statistics counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // FSM state and request context.
    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   addr_next_s;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH-1:0]   data_next_s;
    logic                    hit_r;
    logic                    hit_next_s;
    logic                    hit_inc_s;
    logic                    miss_inc_s;

    // Combinational outputs.
    logic                    req_ready_s;
    logic [ADDR_WIDTH-1:0]   bank_raddr_s;

    // Next values of the registered outputs.
    logic                    rsp_valid_next_s;
    logic [DATA_WIDTH-1:0]   rsp_data_next_s;
    logic                    rsp_hit_next_s;
    logic                    bank_we_next_s;
    logic [ADDR_WIDTH-1:0]   bank_waddr_next_s;
    logic [DATA_WIDTH-1:0]   bank_wdata_next_s;
    logic                    mem_req_valid_next_s;
    logic [ADDR_WIDTH-1:0]   mem_req_addr_next_s;

    // Registered outputs.
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_data_r;
    logic                    rsp_hit_r;
    logic                    bank_we_r;
    logic [ADDR_WIDTH-1:0]   bank_waddr_r;
    logic [DATA_WIDTH-1:0]   bank_wdata_r;
    logic                    mem_req_valid_r;
    logic [ADDR_WIDTH-1:0]   mem_req_addr_r;
    logic [CNT_WIDTH-1:0]    hit_count_r;
    logic [CNT_WIDTH-1:0]    miss_count_r;

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and request-context update; mem_rsp_valid only matters in MEM_WAIT.
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = addr_r;
        data_next_s  = data_r;
        hit_next_s   = hit_r;
        hit_inc_s    = 1'b0;
        miss_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_next_s  = req_addr;
                    state_next_s = ST_PROBE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PROBE: begin
                if (bank_hit) begin
                    data_next_s  = bank_rdata;
                    hit_next_s   = 1'b1;
                    hit_inc_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    hit_next_s   = 1'b0;
                    miss_inc_s   = 1'b1;
                    state_next_s = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) begin
                    state_next_s = ST_MEM_WAIT;
                end else begin
                    state_next_s = ST_MEM_REQ;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    data_next_s  = mem_rsp_data;
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_MEM_WAIT;
                end
            end
            ST_FILL: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: combinational handshake/read address, plus next values of registered outputs.
    always_comb begin
        req_ready_s          = 1'b0;
        bank_raddr_s         = addr_r;
        rsp_valid_next_s     = 1'b0;
        rsp_data_next_s      = DATA_ZERO;
        rsp_hit_next_s       = 1'b0;
        bank_we_next_s       = 1'b0;
        bank_waddr_next_s    = ADDR_ZERO;
        bank_wdata_next_s    = DATA_ZERO;
        mem_req_valid_next_s = 1'b0;
        mem_req_addr_next_s  = ADDR_ZERO;

        // The bank sees the raw request address while idle so its registered
        // read data is ready in the PROBE cycle.
        case (state_r)
            ST_IDLE: begin
                req_ready_s  = 1'b1;
                bank_raddr_s = req_addr;
            end
            default: begin
                req_ready_s  = 1'b0;
                bank_raddr_s = addr_r;
            end
        endcase

        // Registered outputs are driven from the state being entered.
        case (state_next_s)
            ST_RESP: begin
                rsp_valid_next_s = 1'b1;
                rsp_data_next_s  = data_next_s;
                rsp_hit_next_s   = hit_next_s;
            end
            ST_FILL: begin
                bank_we_next_s    = 1'b1;
                bank_waddr_next_s = addr_next_s;
                bank_wdata_next_s = data_next_s;
            end
            ST_MEM_REQ: begin
                mem_req_valid_next_s = 1'b1;
                mem_req_addr_next_s  = addr_next_s;
            end
            default: begin
                rsp_valid_next_s     = 1'b0;
                bank_we_next_s       = 1'b0;
                mem_req_valid_next_s = 1'b0;
            end
        endcase
    end

    // Request context and registered interface outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r          <= ADDR_ZERO;
            data_r          <= DATA_ZERO;
            hit_r           <= 1'b0;
            rsp_valid_r     <= 1'b0;
            rsp_data_r      <= DATA_ZERO;
            rsp_hit_r       <= 1'b0;
            bank_we_r       <= 1'b0;
            bank_waddr_r    <= ADDR_ZERO;
            bank_wdata_r    <= DATA_ZERO;
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= ADDR_ZERO;
        end else begin
            addr_r          <= addr_next_s;
            data_r          <= data_next_s;
            hit_r           <= hit_next_s;
            rsp_valid_r     <= rsp_valid_next_s;
            rsp_data_r      <= rsp_data_next_s;
            rsp_hit_r       <= rsp_hit_next_s;
            bank_we_r       <= bank_we_next_s;
            bank_waddr_r    <= bank_waddr_next_s;
            bank_wdata_r    <= bank_wdata_next_s;
            mem_req_valid_r <= mem_req_valid_next_s;
            mem_req_addr_r  <= mem_req_addr_next_s;
        end
    end

    // Saturating probe hit/miss statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_r  <= CNT_ZERO;
            miss_count_r <= CNT_ZERO;
        end else begin
            if (hit_inc_s) begin
                hit_count_r <= sat_inc(hit_count_r);
            end else begin
                hit_count_r <= hit_count_r;
            end
            if (miss_inc_s) begin
                miss_count_r <= sat_inc(miss_count_r);
            end else begin
                miss_count_r <= miss_count_r;
            end
        end
    end

    assign req_ready     = req_ready_s;
    assign bank_raddr    = bank_raddr_s;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_hit       = rsp_hit_r;
    assign bank_we       = bank_we_r;
    assign bank_waddr    = bank_waddr_r;
    assign bank_wdata    = bank_wdata_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign hit_count     = hit_count_r;
    assign miss_count    = miss_count_r;

endmodule
